// File: rtl/adder_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim_checker
// Brief    : xorshift32 operand source and latency-aligned sum checker
// Revision : 1.0
// ============================================================================
module adder_stim_checker #(
    parameter int          ADDER_WIDTH = 29,
    parameter int          LATENCY     = 2,
    parameter int          NUM_VECTORS = 1000,
    parameter logic [31:0] SEED_A      = 32'h00000001,
    parameter logic [31:0] SEED_B      = 32'h00000001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [ADDER_WIDTH-1:0] a,
    output logic [ADDER_WIDTH-1:0] b,
    input  logic [ADDER_WIDTH:0]   sum,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            error_count,
    output logic [15:0]            first_fail
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_last_vec   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  c_last_drain = 4'(LATENCY - 1);

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    state_t                 r_state;
    state_t                 w_state_next;
    logic [31:0]            r_lfsr_a;
    logic [31:0]            r_lfsr_b;
    logic [15:0]            r_vec_cnt;
    logic [3:0]             r_drain_cnt;
    logic [ADDER_WIDTH-1:0] r_a;
    logic [ADDER_WIDTH-1:0] r_b;
    logic [15:0]            r_err_cnt;
    logic [15:0]            r_first_fail;
    logic                   r_pipe_vld [LATENCY];
    logic [ADDER_WIDTH:0]   r_pipe_exp [LATENCY];
    logic [15:0]            r_pipe_idx [LATENCY];
    logic                   w_last_vec;
    logic                   w_last_drain;
    logic                   w_mismatch;

    assign w_last_vec   = (r_vec_cnt == c_last_vec);
    assign w_last_drain = (r_drain_cnt == c_last_drain);
    assign w_mismatch   = r_pipe_vld[LATENCY-1] && (sum != r_pipe_exp[LATENCY-1]);

    assign a           = r_a;
    assign b           = r_b;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign pass        = (r_state == S_DONE) && (r_err_cnt == 16'd0);
    assign error_count = r_err_cnt;
    assign first_fail  = r_first_fail;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)        w_state_next = S_RUN;
            S_RUN:          if (w_last_vec)   w_state_next = S_DRAIN;
            S_DRAIN:        if (w_last_drain) w_state_next = S_DONE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr_a     <= '0;
            r_lfsr_b     <= '0;
            r_vec_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_exp[i] <= '0;
                r_pipe_idx[i] <= '0;
            end
        end else begin
            // Expected sum tracks the operands currently on a/b; only RUN cycles are tagged valid.
            r_pipe_vld[0] <= (r_state == S_RUN);
            r_pipe_exp[0] <= {1'b0, r_a} + {1'b0, r_b};
            r_pipe_idx[0] <= r_vec_cnt;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_exp[i] <= r_pipe_exp[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end

            if (w_mismatch) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (r_err_cnt == 16'd0) begin
                    r_first_fail <= r_pipe_idx[LATENCY-1];
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Vector 0 is the seed itself; the LFSR runs one step ahead of a/b.
                        r_a          <= SEED_A[ADDER_WIDTH-1:0];
                        r_b          <= SEED_B[ADDER_WIDTH-1:0];
                        r_lfsr_a     <= xorshift32(SEED_A);
                        r_lfsr_b     <= xorshift32(SEED_B);
                        r_vec_cnt    <= '0;
                        r_err_cnt    <= '0;
                        r_first_fail <= '0;
                    end
                end
                S_RUN: begin
                    r_vec_cnt   <= r_vec_cnt + 16'd1;
                    r_drain_cnt <= '0;
                    if (w_last_vec) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else begin
                        r_a      <= r_lfsr_a[ADDER_WIDTH-1:0];
                        r_b      <= r_lfsr_b[ADDER_WIDTH-1:0];
                        r_lfsr_a <= xorshift32(r_lfsr_a);
                        r_lfsr_b <= xorshift32(r_lfsr_b);
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_stim_checker
// Brief    : scoreboard bench with behavioural adder, latency skew and faults
// Revision : 1.0
// ============================================================================
module tb_adder_stim_checker;

    localparam int          W   = 29;
    localparam int          L   = 2;
    localparam int          N   = 24;
    localparam logic [31:0] SA  = 32'h00000001;
    localparam logic [31:0] SB  = 32'hDEADBEEF;
    localparam int          W2  = 2;
    localparam int          L2  = 1;
    localparam int          N2  = 12;
    localparam logic [31:0] SA2 = 32'h00000003;
    localparam logic [31:0] SB2 = 32'h00000007;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic [W-1:0]  a, b;
    logic [W:0]    sum;
    logic          busy, done, pass;
    logic [15:0]   error_count, first_fail;
    logic [W2-1:0] a2, b2;
    logic [W2:0]   sum2;
    logic          busy2, done2, pass2;
    logic [15:0]   error_count2, first_fail2;

    adder_stim_checker #(
        .ADDER_WIDTH(W), .LATENCY(L), .NUM_VECTORS(N), .SEED_A(SA), .SEED_B(SB)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sum(sum),
        .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_fail(first_fail)
    );

    adder_stim_checker #(
        .ADDER_WIDTH(W2), .LATENCY(L2), .NUM_VECTORS(N2), .SEED_A(SA2), .SEED_B(SB2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .sum(sum2),
        .busy(busy2), .done(done2), .pass(pass2),
        .error_count(error_count2), .first_fail(first_fail2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Behavioural adder with selectable latency and a one-vector zero fault.
    int         cyc = 0;
    int         start_cyc = 0;
    int         fault_vec = -1;
    int         model_lat = L;
    logic [W:0] add_pipe [8];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        add_pipe[0] <= (cyc - start_cyc == fault_vec) ? '0 : ({1'b0, a} + {1'b0, b});
        for (int i = 1; i < 8; i++) add_pipe[i] <= add_pipe[i-1];
        sum2 <= {1'b0, a2} + {1'b0, b2};
    end
    assign sum = add_pipe[model_lat-1];

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
    typedef struct { int done_cyc; int err; int ff; logic pass; } summ_t;
    pair_t exp_q[$];
    summ_t sum_q[$];
    int    total = 0;
    int    bad = 0;
    logic  mon_en = 1'b1;
    logic  prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=missing required=present", name);
    endtask

    // Monitor: pops operand expectations while busy, summary expectations at done rise.
    always @(negedge clk) begin
        pair_t p;
        summ_t s;
        if (mon_en && !reset) begin
            if (busy) begin
                if (exp_q.size() == 0) fail_now("busy_unexpected");
                else begin
                    p = exp_q.pop_front();
                    check("a", 64'(a), 64'(p.a));
                    check("b", 64'(b), 64'(p.b));
                end
            end else begin
                check("ab_idle_zero", 64'({a, b}), 64'd0);
            end
            if (done && !prev_done) begin
                if (sum_q.size() == 0) fail_now("done_unexpected");
                else begin
                    s = sum_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(s.done_cyc));
                    check("error_count", 64'(error_count), 64'(s.err));
                    if (s.err != 0) check("first_fail", 64'(first_fail), 64'(s.ff));
                    check("pass", 64'(pass), 64'(s.pass));
                    check("vectors_consumed", 64'(exp_q.size()), 64'd0);
                end
            end
        end
        prev_done <= done;
    end

    task automatic run(input int lat, input int fvec, input int extra);
        logic [31:0] sa, sb;
        logic [W:0]  ts [N];
        logic [W:0]  got;
        pair_t       p;
        summ_t       s;
        int          d, j, errs, ff;
        sa = SA;
        sb = SB;
        for (int i = 0; i < N; i++) begin
            p.a = sa[W-1:0];
            p.b = sb[W-1:0];
            ts[i] = {1'b0, p.a} + {1'b0, p.b};
            exp_q.push_back(p);
            sa = xs32(sa);
            sb = xs32(sb);
        end
        p.a = '0;
        p.b = '0;
        for (int i = 0; i < L; i++) exp_q.push_back(p);
        // Sum seen for vector i is the adder result of vector i-d (0 outside RUN or when faulted).
        d = lat - L;
        errs = 0;
        ff = 0;
        for (int i = 0; i < N; i++) begin
            j = i - d;
            got = (j < 0 || j >= N || j == fvec) ? '0 : ts[j];
            if (got != ts[i]) begin
                if (errs == 0) ff = i;
                errs++;
            end
        end
        model_lat = lat;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        start_cyc = cyc;
        fault_vec = fvec;
        s.done_cyc = start_cyc + N + L;
        s.err = errs;
        s.ff = ff;
        s.pass = (errs == 0);
        sum_q.push_back(s);
        for (int k = 1; k <= N + L + 20; k++) begin
            @(negedge clk);
            start = (k + 1 == extra);
            if (sum_q.size() == 0) break;
        end
        start = 1'b0;
        if (sum_q.size() != 0) fail_now("done_timeout");
        sum_q.delete();
        exp_q.delete();
        fault_vec = -1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_small();
        logic [31:0] sa, sb;
        int          s;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        s = cyc;
        sa = SA2;
        sb = SB2;
        for (int i = 0; i < N2; i++) begin
            check("a2", 64'(a2), 64'(sa[W2-1:0]));
            check("b2", 64'(b2), 64'(sb[W2-1:0]));
            sa = xs32(sa);
            sb = xs32(sb);
            @(negedge clk);
        end
        for (int k = 0; k < 20 && !done2; k++) @(negedge clk);
        check("done2_cycle", 64'(cyc), 64'(s + N2 + L2));
        check("pass2", 64'(pass2), 64'd1);
        check("error_count2", 64'(error_count2), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_ab", 64'({a, b}), 64'd0);
        check("rst_flags", 64'({busy, done, pass}), 64'd0);
        check("rst_counts", 64'({error_count, first_fail}), 64'd0);
        check("rst_dut2", 64'({a2, b2, busy2, done2, pass2, error_count2, first_fail2}), 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        run(L, -1, 0);
        run(L, 5, N + 1);
        run(3, -1, 0);
        run(1, -1, 2);
        for (int r = 0; r < 4; r++) begin
            run($urandom_range(1, 4),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, N - 1)) : -1,
                $urandom_range(2, N + L));
        end

        // Reset in RUN cycle 10 after an error has been recorded.
        mon_en = 1'b0;
        model_lat = L;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        start_cyc = cyc;
        fault_vec = 3;
        repeat (9) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'd1);
        check("err_before_reset", 64'(error_count), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fault_vec = -1;
        check("mid_reset_ab", 64'({a, b}), 64'd0);
        check("mid_reset_flags", 64'({busy, done, pass}), 64'd0);
        check("mid_reset_counts", 64'({error_count, first_fail}), 64'd0);
        repeat (N + L + 5) @(negedge clk);
        check("no_done_after_reset", 64'({busy, done, error_count}), 64'd0);
        mon_en = 1'b1;

        run(L, -1, 0);
        run(L, 0, 0);
        run_small();
        run_small();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
